uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver.
//
// Receives asynchronous serial frames on rx (idle high, LSB first). Each frame has a start bit,
// DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits. Each received word is
// presented on po_data with a one-cycle po_flag pulse. The error status of that word is held on
// frame_err / parity_err until the next po_flag.
//
// Ports:
//   sclk       in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rx         in   serial line, asynchronous to sclk
//   po_data    out  last received word, held until the next po_flag
//   po_flag    out  single-cycle pulse marking a new word on po_data
//   frame_err  out  a stop-bit sample of the word on po_data was 0
//   parity_err out  parity check of the word on po_data failed (0 when PARITY=0)
//   busy       out  high from start-bit detection until the frame ends or is aborted
//
// Optional feature: define RX_MAJORITY_VOTE_EN to take each bit as the 2-of-3 majority of the
// samples at OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2. Without the macro each bit is a
// single sample at OVERSAMPLE/2-1.

module uart_rx_param #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned Div   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DivW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned ScntW = $clog2(OVERSAMPLE);
  localparam logic [ScntW-1:0] ScntLast = ScntW'(OVERSAMPLE - 1);
  localparam logic             OddPar   = (PARITY == 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DivW-1:0]      div_q, div_d;
  logic [ScntW-1:0]     scnt_q, scnt_d;
  logic [ScntW-1:0]     hcnt_q, hcnt_d;
  logic                 armed_q, armed_d;
  logic [2:0]           state_q, state_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] po_data_q, po_data_d;
  logic                 flag_q, flag_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 tick, start_det, sample_en, bit_val;

  // Synchronizer resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign tick      = (div_q == DivW'(Div - 1));
  assign start_det = (state_q == StIdle) && armed_q && rx_prev_q && !rx_sync_q;

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [ScntW-1:0] SampleEarly = ScntW'(OVERSAMPLE / 2 - 2);
  localparam logic [ScntW-1:0] SampleMid   = ScntW'(OVERSAMPLE / 2 - 1);
  localparam logic [ScntW-1:0] SampleLate  = ScntW'(OVERSAMPLE / 2);
  logic [1:0] vote_q;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      vote_q <= 2'b11;
    end else if (tick) begin
      if (scnt_q == SampleEarly) vote_q[0] <= rx_sync_q;
      if (scnt_q == SampleMid)   vote_q[1] <= rx_sync_q;
    end
  end

  assign sample_en = tick && (scnt_q == SampleLate);
  assign bit_val   = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_sync_q) | (vote_q[1] & rx_sync_q);
`else
  localparam logic [ScntW-1:0] SampleMid = ScntW'(OVERSAMPLE / 2 - 1);

  assign sample_en = tick && (scnt_q == SampleMid);
  assign bit_val   = rx_sync_q;
`endif

  always_comb begin
    div_d        = tick ? '0 : div_q + DivW'(1);
    scnt_d       = scnt_q;
    hcnt_d       = hcnt_q;
    armed_d      = armed_q;
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    po_data_d    = po_data_q;
    flag_d       = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    if (tick) scnt_d = (scnt_q == ScntLast) ? '0 : scnt_q + ScntW'(1);
    // Phase-align both counters to the detected start edge.
    if (start_det) begin
      div_d  = '0;
      scnt_d = '0;
    end

    // Arm only after rx has stayed high for a whole bit time.
    if (!rx_sync_q) begin
      hcnt_d = '0;
    end else if (tick && !armed_q) begin
      if (hcnt_q == ScntLast) armed_d = 1'b1;
      else                    hcnt_d  = hcnt_q + ScntW'(1);
    end

    case (state_q)
      StIdle: begin
        if (start_det) state_d = StStart;
      end
      StStart: begin
        if (sample_en) begin
          if (!bit_val) begin
            state_d = StData;
            bcnt_d  = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (sample_en) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ bit_val;
          if (bcnt_q == 4'(DATA_BITS - 1)) begin
            bcnt_d  = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (sample_en) begin
          perr_d  = ((par_q ^ bit_val) != OddPar);
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample_en) begin
          ferr_d = ferr_q | ~bit_val;
          if (bcnt_q == 4'(STOP_BITS - 1)) begin
            po_data_d    = shift_q;
            frame_err_d  = ferr_d;
            parity_err_d = perr_q;
            flag_d       = 1'b1;
            state_d      = StIdle;
            // A bad stop bit may be a break; demand a full idle bit before the next frame.
            if (ferr_d) begin
              armed_d = 1'b0;
              hcnt_d  = '0;
            end
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      scnt_q       <= '0;
      hcnt_q       <= '0;
      armed_q      <= 1'b0;
      state_q      <= StIdle;
      bcnt_q       <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      po_data_q    <= '0;
      flag_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      scnt_q       <= scnt_d;
      hcnt_q       <= hcnt_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      po_data_q    <= po_data_d;
      flag_q       <= flag_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign po_data    = po_data_q;
  assign po_flag    = flag_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Bench for uart_rx_param: a default 8N1 instance and an even-parity instance, each fed by its
// own rx line. Expected words are queued as frames are sent and checked as po_flag pulses.

module tb_uart_rx_param;

  localparam int BitNs = 8680;

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic       rx   = 1'b1;
  logic       rx_p = 1'b1;
  logic [7:0] po_data, po_data_p;
  logic       po_flag, frame_err, parity_err, busy;
  logic       po_flag_p, frame_err_p, parity_err_p, busy_p;

  uart_rx_param dut (
    .sclk      (sclk),
    .rst       (rst),
    .rx        (rx),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  uart_rx_param #(.PARITY(2)) dut_p (
    .sclk      (sclk),
    .rst       (rst),
    .rx        (rx_p),
    .po_data   (po_data_p),
    .po_flag   (po_flag_p),
    .frame_err (frame_err_p),
    .parity_err(parity_err_p),
    .busy      (busy_p)
  );

  always #10 sclk = ~sclk;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q[$];
  exp_t q_p[$];
  exp_t e, e_p;
  int   checks  = 0;
  int   errors  = 0;
  int   nflag   = 0;
  int   nflag_p = 0;

  // Scoreboard: every po_flag must match the oldest queued expectation.
  always @(negedge sclk) begin
    if (po_flag === 1'b1) begin
      nflag++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got flag data=%h fe=%b pe=%b required no flag",
                 po_data, frame_err, parity_err);
      end else begin
        e = q.pop_front();
        if ({po_data, frame_err, parity_err} !== {e.d, e.fe, e.pe}) begin
          errors++;
          $display("FAIL sb_word: got data=%h fe=%b pe=%b required data=%h fe=%b pe=%b",
                   po_data, frame_err, parity_err, e.d, e.fe, e.pe);
        end
      end
    end
    if (po_flag_p === 1'b1) begin
      nflag_p++;
      checks++;
      if (q_p.size() == 0) begin
        errors++;
        $display("FAIL sb_p_unexpected: got flag data=%h fe=%b pe=%b required no flag",
                 po_data_p, frame_err_p, parity_err_p);
      end else begin
        e_p = q_p.pop_front();
        if ({po_data_p, frame_err_p, parity_err_p} !== {e_p.d, e_p.fe, e_p.pe}) begin
          errors++;
          $display("FAIL sb_p_word: got data=%h fe=%b pe=%b required data=%h fe=%b pe=%b",
                   po_data_p, frame_err_p, parity_err_p, e_p.d, e_p.fe, e_p.pe);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input bit line, input logic v);
    if (line) rx_p = v;
    else      rx   = v;
  endtask

  // Line is left at the stop value, so back-to-back calls give 100% utilisation.
  task automatic send_frame(input bit line, input logic [7:0] d, input bit has_par,
                            input bit par_bit, input bit stop_v);
    drive(line, 1'b0);
    #(BitNs);
    for (int i = 0; i < 8; i++) begin
      drive(line, d[i]);
      #(BitNs);
    end
    if (has_par) begin
      drive(line, par_bit);
      #(BitNs);
    end
    drive(line, stop_v);
    #(BitNs);
  endtask

  task automatic test_reset();
    #100;
    checks++;
    if ({po_data, po_flag, frame_err, parity_err, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got data=%h flag=%b fe=%b pe=%b busy=%b required all 0",
               po_data, po_flag, frame_err, parity_err, busy);
    end
    checks++;
    if ({po_data_p, po_flag_p, frame_err_p, parity_err_p, busy_p} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state_p: got data=%h flag=%b fe=%b pe=%b busy=%b required all 0",
               po_data_p, po_flag_p, frame_err_p, parity_err_p, busy_p);
    end
    #100 rst = 1'b0;
  endtask

  task automatic test_basic();
    int n0;
    // The receiver arms only after a full bit time of idle line.
    #(2 * BitNs);
    n0 = nflag;
    q.push_back({8'h55, 1'b0, 1'b0});
    fork
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      begin
        #(3 * BitNs);
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_busy_mid: got %b required 1", busy);
        end
      end
    join
    #(BitNs / 4);
    checks++;
    if (nflag - n0 != 1) begin
      errors++;
      $display("FAIL basic_flag_count: got %0d required 1", nflag - n0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_end: got %b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = nflag;
    q.push_back({8'hAA, 1'b0, 1'b0});
    q.push_back({8'h12, 1'b0, 1'b0});
    send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    #(BitNs / 4);
    checks++;
    if (nflag - n0 != 2 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_flags: got %0d flags, %0d pending required 2 flags, 0 pending",
               nflag - n0, q.size());
    end
  endtask

  task automatic test_parity();
    q_p.push_back({8'hA5, 1'b0, 1'b1});
    send_frame(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
    #(BitNs / 4);
    checks++;
    if (parity_err_p !== 1'b1 || q_p.size() != 0) begin
      errors++;
      $display("FAIL parity_bad_held: got pe=%b pending=%0d required pe=1 pending=0",
               parity_err_p, q_p.size());
    end
    q_p.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    #(BitNs / 4);
    checks++;
    if ({po_data_p, parity_err_p} !== {8'h3C, 1'b0} || q_p.size() != 0) begin
      errors++;
      $display("FAIL parity_good_held: got data=%h pe=%b pending=%0d required 3c 0 0",
               po_data_p, parity_err_p, q_p.size());
    end
  endtask

  task automatic test_frame_err();
    int n0;
    q.push_back({8'h81, 1'b1, 1'b0});
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    #(2 * BitNs);
    checks++;
    if (frame_err !== 1'b1 || q.size() != 0) begin
      errors++;
      $display("FAIL ferr_flag: got fe=%b pending=%0d required fe=1 pending=0",
               frame_err, q.size());
    end
    // A short high followed by a fall must not start a frame while disarmed.
    n0 = nflag;
    rx = 1'b1;
    #(BitNs / 4);
    rx = 1'b0;
    #(2 * BitNs);
    checks++;
    if (busy !== 1'b0 || nflag != n0) begin
      errors++;
      $display("FAIL ferr_disarmed: got busy=%b flags=%0d required busy=0 flags=0",
               busy, nflag - n0);
    end
    rx = 1'b1;
    #(3 * BitNs / 2);
    q.push_back({8'h7E, 1'b0, 1'b0});
    send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
    #(BitNs / 4);
    checks++;
    if (frame_err !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL ferr_recover: got fe=%b pending=%0d required fe=0 pending=0",
               frame_err, q.size());
    end
  endtask

  task automatic test_false_start();
    int n0;
    n0 = nflag;
    rx = 1'b0;
    #1000;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL false_start_busy: got %b required 1", busy);
    end
    #1000;
    rx = 1'b1;
    #(2 * BitNs);
    checks++;
    if (busy !== 1'b0 || nflag != n0) begin
      errors++;
      $display("FAIL false_start_end: got busy=%b flags=%0d required busy=0 flags=0",
               busy, nflag - n0);
    end
    // rx held low across reset release must not produce a frame.
    rst = 1'b1;
    rx  = 1'b0;
    #200;
    rst = 1'b0;
    #(3 * BitNs);
    checks++;
    if (busy !== 1'b0 || nflag != n0) begin
      errors++;
      $display("FAIL low_at_reset: got busy=%b flags=%0d required busy=0 flags=0",
               busy, nflag - n0);
    end
    rx = 1'b1;
    #(2 * BitNs);
    q.push_back({8'h5A, 1'b0, 1'b0});
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    #(BitNs / 4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL low_at_reset_recover: got %0d pending required 0", q.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int         n0;
    d  = 8'h33;
    n0 = nflag;
    rx = 1'b0;
    #(BitNs);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      #(BitNs);
    end
    rx = d[4];
    #(BitNs / 2);
    rst = 1'b1;
    #1;
    checks++;
    if ({po_data, po_flag, busy} !== 10'h000) begin
      errors++;
      $display("FAIL midframe_reset: got data=%h flag=%b busy=%b required 00 0 0",
               po_data, po_flag, busy);
    end
    #200;
    rx  = 1'b1;
    rst = 1'b0;
    #(2 * BitNs);
    q.push_back({8'hC3, 1'b0, 1'b0});
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    #(BitNs / 4);
    checks++;
    if (po_data !== 8'hC3 || nflag - n0 != 1) begin
      errors++;
      $display("FAIL midframe_recover: got data=%h flags=%0d required c3 1",
               po_data, nflag - n0);
    end
  endtask

`ifdef RX_MAJORITY_VOTE_EN
  task automatic test_majority();
    logic [7:0] d;
    d = 8'hF0;
    q.push_back({8'hF0, 1'b0, 1'b0});
    rx = 1'b0;
    #(BitNs);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(BitNs / 2 - 10);
      rx = ~d[i];
      #20;
      rx = d[i];
      #(BitNs / 2 - 10);
    end
    rx = 1'b1;
    #(BitNs);
    #(BitNs / 4);
    checks++;
    if (po_data !== 8'hF0 || q.size() != 0) begin
      errors++;
      $display("FAIL majority_glitch: got data=%h pending=%0d required f0 0",
               po_data, q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_false_start();
    test_reset_midframe();
`ifdef RX_MAJORITY_VOTE_EN
    test_majority();
`endif
    #(BitNs);
    checks++;
    if (q.size() != 0 || q_p.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d/%0d pending required 0/0", q.size(), q_p.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
